ecc_issue_decoder: RTL and testbench
====================================

Name: ecc_issue_decoder

Overview:
Issue-stage front end of the ECC accelerator on the CV-X-IF port.
- Decodes each offloaded instruction against the custom1 ECC opcode table (load/add/sub/mul/inv) and returns the issue response in the same cycle.
- Buffers accepted operations with their operands in a small in-order FIFO.
- Dispatches queued operations to the ECC execution core through a valid/ready handshake.

Parameters:
XLEN, 64, operand width of rs1/rs2.
IdWidth, 3, CV-X-IF instruction id width.
Depth, 4, FIFO entries; power of two, at least 2.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
issue_valid_i  in  1  core offers an instruction.
issue_ready_o  out  1  decoder takes the offer this cycle.
issue_instr_i  in  32  instruction word.
issue_id_i  in  IdWidth  instruction id.
issue_rs1_i  in  XLEN  rs1 value.
issue_rs2_i  in  XLEN  rs2 value.
issue_rs_valid_i  in  2  rs1/rs2 operand valid flags.
issue_resp_o  out  cvxif_pkg::x_issue_resp_t  accept/writeback/dualwrite/dualread/loadstore/exc.
flush_i  in  1  kill all queued operations.
op_valid_o  out  1  FIFO head valid.
op_ready_i  in  1  ECC core consumes the head.
op_code_o  out  3  ecc_op_e: LOAD=0, ADD=1, SUB=2, MUL=3, INV=4.
op_id_o  out  IdWidth  id of the head entry.
op_rd_o  out  5  destination register, instr[11:7].
op_wb_o  out  1  head entry requires a result writeback.
op_rs1_o  out  XLEN  head rs1.
op_rs2_o  out  XLEN  head rs2.
fifo_count_o  out  $clog2(Depth)+1  number of occupied entries.

Behaviour:
- Decode (combinational):
  - Match when (instr & mask) == pattern for a table entry.
  - Shared mask 0x0000_707F; opcode 0x2B; funct3 in bits [14:12].
  - funct3 000 = LOAD, 001 = ADD, 010 = SUB, 011 = MUL, 100 = INV.
  - funct3 101/110/111, or any other opcode, is no match.
- issue_resp_o is a pure function of issue_instr_i and is valid whenever issue_valid_i is high.
  - Match: accept=1, writeback=1 except LOAD (writeback=0).
  - No match: all fields 0.
  - dualwrite, dualread, loadstore and exc are always 0.
- issue_ready_o:
  - No match: 1, regardless of FIFO state (the reject is consumed immediately).
  - Match: 1 only when issue_rs_valid_i==2'b11, the registered FIFO state is not full, and flush_i is low.
  - There is no combinational path from op_ready_i to issue_ready_o. When the FIFO is full, a dequeue in that cycle does not open a slot until the next cycle.
- Enqueue on issue_valid_i & issue_ready_o & match. Write {op, id, rd, wb, rs1, rs2} at wr_ptr.
- Dequeue on op_valid_o & op_ready_i, advancing rd_ptr.
- Pointers wrap modulo Depth; count tracks occupancy.
  - Simultaneous enqueue and dequeue leaves count unchanged.
- Outputs are driven straight from the head entry storage: latency is 1 cycle from the issue handshake to op_valid_o for an empty FIFO.
- While op_valid_o=1 and op_ready_i=0, all op_* outputs stay stable.
- flush_i:
  - Next edge: count=0 and pointers=0.
  - Blocks any enqueue in the flush cycle; a dequeue in the same cycle is ignored.
- Reset (asynchronous): pointers=0, count=0, op_valid_o=0, fifo_count_o=0. Payload storage need not be reset.
  - A reset in mid-operation drops all entries.

Decomposition:
- Add to the shared ECC package:
  - ecc_op_e.
  - The instruction pattern and mask constants.
  - The ecc_fifo_entry_t struct.
  - A decode function returning {match, op, resp}.
- One sub-module: ecc_op_fifo, a generic synchronous FIFO with flush and count, parameterised on entry type and Depth.

Test Plan:
- ADD 0x006293AB, id=2, rs_valid=11, rs1=0x11, rs2=0x22, empty FIFO -> same cycle: ready=1, accept=1, writeback=1. Next cycle: op_valid=1, op_code=1, op_rd=7, op_id=2, op_rs1=0x11, op_rs2=0x22.
- LOAD 0x006283AB -> accept=1, writeback=0, op_wb=0. INV 0x0062C3AB -> op_code=4, op_wb=1.
- 0x0062D3AB (funct3 101) and 0x00000033 (OP) -> ready=1, accept=0, no enqueue, fifo_count unchanged, including when the FIFO is full.
- op_ready_i=0 with 5 back-to-back ADDs -> 4 accepted, fifo_count=4, 5th sees ready=0. Pulse op_ready_i once -> the 5th enters the cycle after, and entries leave in id order.
- Matching ADD with rs_valid=10 -> ready=0 until rs_valid=11, then enqueue.
- FIFO holding 3 entries, flush_i plus a simultaneous valid ADD -> ready=0, and next cycle fifo_count=0, op_valid=0. Assert rst_ni low mid-stream -> outputs return to 0 immediately.

Source files
------------

// File: rtl/cvxif_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cvxif_pkg: CV-X-IF issue response type used by the ECC issue front end.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cvxif_pkg;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

endpackage : cvxif_pkg
`default_nettype wire

// File: rtl/ecc_issue_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ecc_issue_decoder_pkg: ECC opcode table, FIFO entry type and decoder.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ecc_issue_decoder_pkg;

  localparam int unsigned ECC_XLEN     = 64;
  localparam int unsigned ECC_ID_WIDTH = 3;

  typedef enum logic [2:0] {
    ECC_LOAD = 3'd0,
    ECC_ADD  = 3'd1,
    ECC_SUB  = 3'd2,
    ECC_MUL  = 3'd3,
    ECC_INV  = 3'd4
  } ecc_op_e;

  // custom1 opcode with funct3 selecting the operation; all entries share one mask
  localparam logic [31:0] ECC_MASK     = 32'h0000_707F;
  localparam logic [31:0] ECC_PAT_LOAD = 32'h0000_002B;
  localparam logic [31:0] ECC_PAT_ADD  = 32'h0000_102B;
  localparam logic [31:0] ECC_PAT_SUB  = 32'h0000_202B;
  localparam logic [31:0] ECC_PAT_MUL  = 32'h0000_302B;
  localparam logic [31:0] ECC_PAT_INV  = 32'h0000_402B;

  typedef struct packed {
    ecc_op_e                 op;
    logic [ECC_ID_WIDTH-1:0] id;
    logic [4:0]              rd;
    logic                    wb;
    logic [ECC_XLEN-1:0]     rs1;
    logic [ECC_XLEN-1:0]     rs2;
  } ecc_fifo_entry_t;

  typedef struct packed {
    logic                     match;
    ecc_op_e                  op;
    cvxif_pkg::x_issue_resp_t resp;
  } ecc_decode_t;

  function automatic ecc_decode_t ecc_decode(input logic [31:0] instr);
    ecc_decode_t d;
    logic [31:0] masked;
    d      = '0;
    masked = instr & ECC_MASK;
    if (masked == ECC_PAT_LOAD) begin
      d.match = 1'b1;
      d.op    = ECC_LOAD;
    end else if (masked == ECC_PAT_ADD) begin
      d.match = 1'b1;
      d.op    = ECC_ADD;
    end else if (masked == ECC_PAT_SUB) begin
      d.match = 1'b1;
      d.op    = ECC_SUB;
    end else if (masked == ECC_PAT_MUL) begin
      d.match = 1'b1;
      d.op    = ECC_MUL;
    end else if (masked == ECC_PAT_INV) begin
      d.match = 1'b1;
      d.op    = ECC_INV;
    end
    d.resp.accept    = d.match;
    d.resp.writeback = d.match && (d.op != ECC_LOAD);
    return d;
  endfunction

endpackage : ecc_issue_decoder_pkg
`default_nettype wire

// File: rtl/ecc_issue_decoder_op_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ecc_op_fifo: generic in-order FIFO with flush and occupancy count.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ecc_op_fifo #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  T                         data_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic                     valid_o,
  output T                         data_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  T              mem_q [Depth];
  T              mem_d [Depth];
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(Depth));
  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // flush dominates both sides, so a same-cycle pop is dropped with the queue
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && valid_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + CW'(1);
      end else if (!push_ok && pop_ok) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule : ecc_op_fifo
`default_nettype wire

// File: rtl/ecc_issue_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ecc_issue_decoder: CV-X-IF issue decode and operation queue for ECC core.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ecc_issue_decoder
  import ecc_issue_decoder_pkg::*;
#(
  parameter int unsigned XLEN    = ECC_XLEN,
  parameter int unsigned IdWidth = ECC_ID_WIDTH,
  parameter int unsigned Depth   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      issue_valid_i,
  output logic                      issue_ready_o,
  input  logic [31:0]               issue_instr_i,
  input  logic [IdWidth-1:0]        issue_id_i,
  input  logic [XLEN-1:0]           issue_rs1_i,
  input  logic [XLEN-1:0]           issue_rs2_i,
  input  logic [1:0]                issue_rs_valid_i,
  output cvxif_pkg::x_issue_resp_t  issue_resp_o,
  input  logic                      flush_i,
  output logic                      op_valid_o,
  input  logic                      op_ready_i,
  output logic [2:0]                op_code_o,
  output logic [IdWidth-1:0]        op_id_o,
  output logic [4:0]                op_rd_o,
  output logic                      op_wb_o,
  output logic [XLEN-1:0]           op_rs1_o,
  output logic [XLEN-1:0]           op_rs2_o,
  output logic [$clog2(Depth):0]    fifo_count_o
);

  // XLEN and IdWidth must stay equal to the widths baked into ecc_fifo_entry_t
  ecc_decode_t     dec;
  ecc_fifo_entry_t wr_entry;
  ecc_fifo_entry_t head;
  logic            fifo_full;
  logic            push;

  assign dec          = ecc_decode(issue_instr_i);
  assign issue_resp_o = dec.resp;

  // fifo_full is registered, so a dequeue never frees a slot in the same cycle
  assign issue_ready_o = !dec.match ||
                         ((issue_rs_valid_i == 2'b11) && !fifo_full && !flush_i);
  assign push          = issue_valid_i && issue_ready_o && dec.match;

  always_comb begin
    wr_entry     = '0;
    wr_entry.op  = dec.op;
    wr_entry.id  = issue_id_i;
    wr_entry.rd  = issue_instr_i[11:7];
    wr_entry.wb  = dec.resp.writeback;
    wr_entry.rs1 = issue_rs1_i;
    wr_entry.rs2 = issue_rs2_i;
  end

  ecc_op_fifo #(
    .T     (ecc_fifo_entry_t),
    .Depth (Depth)
  ) u_op_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (wr_entry),
    .full_o  (fifo_full),
    .pop_i   (op_ready_i),
    .valid_o (op_valid_o),
    .data_o  (head),
    .count_o (fifo_count_o)
  );

  assign op_code_o = head.op;
  assign op_id_o   = head.id;
  assign op_rd_o   = head.rd;
  assign op_wb_o   = head.wb;
  assign op_rs1_o  = head.rs1;
  assign op_rs2_o  = head.rs2;

endmodule : ecc_issue_decoder
`default_nettype wire

// File: tb/tb_ecc_issue_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ecc_issue_decoder: scoreboard bench for the ECC issue decoder.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ecc_issue_decoder;

  localparam int DEPTH = 4;
  localparam logic [31:0] I_ADD  = 32'h0062_93AB;
  localparam logic [31:0] I_LOAD = 32'h0062_83AB;
  localparam logic [31:0] I_INV  = 32'h0062_C3AB;
  localparam logic [31:0] I_F101 = 32'h0062_D3AB;
  localparam logic [31:0] I_OP   = 32'h0000_0033;

  logic                     clk;
  logic                     rst_ni;
  logic                     issue_valid_i;
  logic                     issue_ready_o;
  logic [31:0]              issue_instr_i;
  logic [2:0]               issue_id_i;
  logic [63:0]              issue_rs1_i;
  logic [63:0]              issue_rs2_i;
  logic [1:0]               issue_rs_valid_i;
  cvxif_pkg::x_issue_resp_t issue_resp_o;
  logic                     flush_i;
  logic                     op_valid_o;
  logic                     op_ready_i;
  logic [2:0]               op_code_o;
  logic [2:0]               op_id_o;
  logic [4:0]               op_rd_o;
  logic                     op_wb_o;
  logic [63:0]              op_rs1_o;
  logic [63:0]              op_rs2_o;
  logic [2:0]               fifo_count_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  id;
    logic [4:0]  rd;
    logic        wb;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  logic m_acc;

  ecc_issue_decoder #(.XLEN(64), .IdWidth(3), .Depth(DEPTH)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .issue_valid_i    (issue_valid_i),
    .issue_ready_o    (issue_ready_o),
    .issue_instr_i    (issue_instr_i),
    .issue_id_i       (issue_id_i),
    .issue_rs1_i      (issue_rs1_i),
    .issue_rs2_i      (issue_rs2_i),
    .issue_rs_valid_i (issue_rs_valid_i),
    .issue_resp_o     (issue_resp_o),
    .flush_i          (flush_i),
    .op_valid_o       (op_valid_o),
    .op_ready_i       (op_ready_i),
    .op_code_o        (op_code_o),
    .op_id_o          (op_id_o),
    .op_rd_o          (op_rd_o),
    .op_wb_o          (op_wb_o),
    .op_rs1_o         (op_rs1_o),
    .op_rs2_o         (op_rs2_o),
    .fifo_count_o     (fifo_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_match(input logic [31:0] ins);
    return (ins[6:0] == 7'h2B) && (ins[14:12] <= 3'd4);
  endfunction

  function automatic logic [5:0] resp_bits(input cvxif_pkg::x_issue_resp_t r);
    return {r.accept, r.writeback, r.dualwrite, r.dualread, r.loadstore, r.exc};
  endfunction

  // Scoreboard: checks head/count every cycle, then applies this cycle's handshakes
  always @(negedge clk) begin
    if (!rst_ni) begin
      sb.delete();
      checks++;
      if (op_valid_o !== 1'b0 || fifo_count_o !== 3'd0) begin
        errors++;
        $display("FAIL reset_hold: op_valid=%b count=%0d, required 0/0", op_valid_o, fifo_count_o);
      end
    end else begin
      checks++;
      if (fifo_count_o !== 3'(sb.size())) begin
        errors++;
        $display("FAIL sb_count: count=%0d, required %0d", fifo_count_o, sb.size());
      end
      checks++;
      if (sb.size() == 0) begin
        if (op_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL sb_empty: op_valid=%b, required 0", op_valid_o);
        end
      end else if (op_valid_o !== 1'b1 ||
                   {op_code_o, op_id_o, op_rd_o, op_wb_o, op_rs1_o, op_rs2_o} !==
                   {sb[0].op, sb[0].id, sb[0].rd, sb[0].wb, sb[0].rs1, sb[0].rs2}) begin
        errors++;
        $display("FAIL sb_head: valid=%b op=%0d id=%0d rd=%0d wb=%b rs1=%h rs2=%h, required op=%0d id=%0d rd=%0d wb=%b rs1=%h rs2=%h",
                 op_valid_o, op_code_o, op_id_o, op_rd_o, op_wb_o, op_rs1_o, op_rs2_o,
                 sb[0].op, sb[0].id, sb[0].rd, sb[0].wb, sb[0].rs1, sb[0].rs2);
      end
      if (flush_i) begin
        sb.delete();
      end else begin
        m_acc = issue_valid_i && model_match(issue_instr_i) &&
                (issue_rs_valid_i == 2'b11) && (sb.size() < DEPTH);
        if (sb.size() > 0 && op_ready_i) void'(sb.pop_front());
        if (m_acc) begin
          m_e.op  = issue_instr_i[14:12];
          m_e.id  = issue_id_i;
          m_e.rd  = issue_instr_i[11:7];
          m_e.wb  = (issue_instr_i[14:12] != 3'd0);
          m_e.rs1 = issue_rs1_i;
          m_e.rs2 = issue_rs2_i;
          sb.push_back(m_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [2:0] id,
                       input logic [63:0] a, input logic [63:0] b, input logic [1:0] rsv);
    issue_valid_i    = 1'b1;
    issue_instr_i    = ins;
    issue_id_i       = id;
    issue_rs1_i      = a;
    issue_rs2_i      = b;
    issue_rs_valid_i = rsv;
  endtask

  task automatic idle();
    issue_valid_i    = 1'b0;
    issue_instr_i    = '0;
    issue_id_i       = '0;
    issue_rs1_i      = '0;
    issue_rs2_i      = '0;
    issue_rs_valid_i = '0;
  endtask

  task automatic test_reset();
    idle();
    flush_i    = 1'b0;
    op_ready_i = 1'b0;
    rst_ni     = 1'b1;
    #2 rst_ni  = 1'b0;
    #1;
    checks++;
    if (op_valid_o !== 1'b0 || fifo_count_o !== 3'd0 || issue_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b count=%0d ready=%b, required 0/0/1",
               op_valid_o, fifo_count_o, issue_ready_o);
    end
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_add();
    op_ready_i = 1'b0;
    drive(I_ADD, 3'd2, 64'h11, 64'h22, 2'b11);
    #3;
    checks++;
    if (issue_ready_o !== 1'b1 || resp_bits(issue_resp_o) !== 6'b110000) begin
      errors++;
      $display("FAIL add_resp: ready=%b resp=%b, required 1/110000", issue_ready_o, resp_bits(issue_resp_o));
    end
    tick();
    idle();
    #3;
    checks++;
    if ({op_valid_o, op_code_o, op_rd_o, op_id_o, op_rs1_o, op_rs2_o} !==
        {1'b1, 3'd1, 5'd7, 3'd2, 64'h11, 64'h22}) begin
      errors++;
      $display("FAIL add_head: valid=%b op=%0d rd=%0d id=%0d rs1=%h rs2=%h, required 1/1/7/2/11/22",
               op_valid_o, op_code_o, op_rd_o, op_id_o, op_rs1_o, op_rs2_o);
    end
    op_ready_i = 1'b1;
    tick();
    op_ready_i = 1'b0;
    tick();
  endtask

  task automatic test_load_inv();
    op_ready_i = 1'b0;
    drive(I_LOAD, 3'd3, 64'hA, 64'hB, 2'b11);
    #3;
    checks++;
    if (issue_ready_o !== 1'b1 || resp_bits(issue_resp_o) !== 6'b100000) begin
      errors++;
      $display("FAIL load_resp: ready=%b resp=%b, required 1/100000", issue_ready_o, resp_bits(issue_resp_o));
    end
    tick();
    drive(I_INV, 3'd4, 64'hC, 64'hD, 2'b11);
    #3;
    checks++;
    if (resp_bits(issue_resp_o) !== 6'b110000 || op_wb_o !== 1'b0 || op_code_o !== 3'd0) begin
      errors++;
      $display("FAIL inv_resp_load_head: resp=%b head_wb=%b head_op=%0d, required 110000/0/0",
               resp_bits(issue_resp_o), op_wb_o, op_code_o);
    end
    tick();
    idle();
    op_ready_i = 1'b1;
    tick();
    #3;
    checks++;
    if (op_code_o !== 3'd4 || op_wb_o !== 1'b1) begin
      errors++;
      $display("FAIL inv_head: op=%0d wb=%b, required 4/1", op_code_o, op_wb_o);
    end
    tick();
    op_ready_i = 1'b0;
    tick();
  endtask

  task automatic test_no_match();
    logic [31:0] bad [2];
    bad[0] = I_F101;
    bad[1] = I_OP;
    for (int i = 0; i < 2; i++) begin
      drive(bad[i], 3'd1, 64'h5, 64'h6, 2'b11);
      #3;
      checks++;
      if (issue_ready_o !== 1'b1 || resp_bits(issue_resp_o) !== 6'b000000) begin
        errors++;
        $display("FAIL nomatch_%0d: ready=%b resp=%b, required 1/000000", i, issue_ready_o, resp_bits(issue_resp_o));
      end
      tick();
    end
    idle();
    #3;
    checks++;
    if (fifo_count_o !== 3'd0) begin
      errors++;
      $display("FAIL nomatch_count: count=%0d, required 0", fifo_count_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    op_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(I_ADD, 3'(i), 64'h100 + 64'(i), 64'h200 + 64'(i), 2'b11);
      #3;
      exp_rdy = (i < 4);
      checks++;
      if (issue_ready_o !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_ready_%0d: ready=%b, required %b", i, issue_ready_o, exp_rdy);
      end
      tick();
    end
    drive(I_F101, 3'd7, 64'h0, 64'h0, 2'b11);
    #3;
    checks++;
    if (fifo_count_o !== 3'd4 || issue_ready_o !== 1'b1 || issue_resp_o.accept !== 1'b0) begin
      errors++;
      $display("FAIL full_nomatch: count=%0d ready=%b accept=%b, required 4/1/0",
               fifo_count_o, issue_ready_o, issue_resp_o.accept);
    end
    tick();
    drive(I_OP, 3'd7, 64'h0, 64'h0, 2'b11);
    tick();
    drive(I_ADD, 3'd4, 64'h104, 64'h204, 2'b11);
    op_ready_i = 1'b1;
    #3;
    checks++;
    if (issue_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_deq_ready: ready=%b, required 0", issue_ready_o);
    end
    tick();
    op_ready_i = 1'b0;
    #3;
    checks++;
    if (issue_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL after_deq_ready: ready=%b, required 1", issue_ready_o);
    end
    tick();
    idle();
    op_ready_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #3;
      checks++;
      if (op_id_o !== 3'(i) || op_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL drain_order_%0d: valid=%b id=%0d, required 1/%0d", i, op_valid_o, op_id_o, i);
      end
      tick();
    end
    op_ready_i = 1'b0;
    tick();
  endtask

  task automatic test_rs_valid();
    op_ready_i = 1'b0;
    drive(I_ADD, 3'd5, 64'h55, 64'h66, 2'b10);
    for (int i = 0; i < 2; i++) begin
      #3;
      checks++;
      if (issue_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL rsv_wait_%0d: ready=%b, required 0", i, issue_ready_o);
      end
      tick();
    end
    issue_rs_valid_i = 2'b11;
    #3;
    checks++;
    if (issue_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rsv_go: ready=%b, required 1", issue_ready_o);
    end
    tick();
    idle();
    #3;
    checks++;
    if (fifo_count_o !== 3'd1 || op_id_o !== 3'd5) begin
      errors++;
      $display("FAIL rsv_enq: count=%0d id=%0d, required 1/5", fifo_count_o, op_id_o);
    end
    op_ready_i = 1'b1;
    tick();
    op_ready_i = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    op_ready_i = 1'b0;
    for (int i = 1; i < 4; i++) begin
      drive(I_ADD, 3'(i), 64'(i), 64'(i), 2'b11);
      tick();
    end
    drive(I_ADD, 3'd6, 64'h6, 64'h6, 2'b11);
    flush_i    = 1'b1;
    op_ready_i = 1'b1;
    #3;
    checks++;
    if (issue_ready_o !== 1'b0 || fifo_count_o !== 3'd3) begin
      errors++;
      $display("FAIL flush_ready: ready=%b count=%0d, required 0/3", issue_ready_o, fifo_count_o);
    end
    tick();
    flush_i    = 1'b0;
    op_ready_i = 1'b0;
    idle();
    #3;
    checks++;
    if (fifo_count_o !== 3'd0 || op_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: count=%0d valid=%b, required 0/0", fifo_count_o, op_valid_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    op_ready_i = 1'b0;
    drive(I_ADD, 3'd1, 64'h1, 64'h2, 2'b11);
    tick();
    drive(I_INV, 3'd2, 64'h3, 64'h4, 2'b11);
    tick();
    idle();
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (op_valid_o !== 1'b0 || fifo_count_o !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b count=%0d, required 0/0", op_valid_o, fifo_count_o);
    end
    tick();
    tick();
    rst_ni = 1'b1;
    drive(I_ADD, 3'd3, 64'h77, 64'h88, 2'b11);
    tick();
    idle();
    #3;
    checks++;
    if (op_valid_o !== 1'b1 || op_id_o !== 3'd3 || fifo_count_o !== 3'd1) begin
      errors++;
      $display("FAIL post_reset_enq: valid=%b id=%0d count=%0d, required 1/3/1", op_valid_o, op_id_o, fifo_count_o);
    end
    op_ready_i = 1'b1;
    tick();
    op_ready_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_inv();
    test_no_match();
    test_back_to_back();
    test_rs_valid();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ecc_issue_decoder
`default_nettype wire
